// File: rtl/muldiv_if.sv
// Mul/div unit pipeline-side bundle: operation request, operands, HI/LO moves and results.
// Latency: none (plain wires).
// Backpressure: alu_stall from the unit holds EX; reg_stall/reg_flush come from the pipeline.
//
// Ports (master = EX pipeline, slave = muldiv_unit):
//   reg_stall, reg_flush      pipeline hold / squash of the EX instruction
//   op, sign                  operation select and signed-operand flag
//   source_a, source_b        operands (source_a is also MTHI/MTLO data)
//   hi_write, lo_write        MTHI / MTLO requests
//   alu_stall                 unit busy
//   hi, lo                    HI/LO register contents
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             reg_stall;
    logic             reg_flush;
    logic             alu_stall;
    logic [2:0]       op;
    logic             sign;
    logic [WIDTH-1:0] source_a;
    logic [WIDTH-1:0] source_b;
    logic             hi_write;
    logic             lo_write;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output reg_stall, reg_flush, op, sign, source_a, source_b, hi_write, lo_write,
        input  alu_stall, hi, lo
    );

    modport slave (
        input  reg_stall, reg_flush, op, sign, source_a, source_b, hi_write, lo_write,
        output alu_stall, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply / multiply-accumulate / restoring divide unit with private HI/LO.
// Latency: MUL_CYCLES+1 stall cycles for MULT/MADD/MSUB, WIDTH+2 for DIV, 2 for divide by zero.
// Backpressure: asserts alu_stall while running; holds in DONE while reg_stall so nothing re-executes.
//
// Ports:
//   clk   clock, all state changes on the rising edge
//   rst   asynchronous active-low reset
//   bus   muldiv_if slave: op/sign/operands/MTHI/MTLO in, alu_stall/hi/lo out
module muldiv_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 2,
    parameter int CNT_W      = 6
) (
    input  logic    clk,
    input  logic    rst,
    muldiv_if.slave bus
);

    localparam logic [2:0] OP_MULT = 3'd1;
    localparam logic [2:0] OP_DIV  = 3'd2;
    localparam logic [2:0] OP_MADD = 3'd3;
    localparam logic [2:0] OP_MSUB = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         op_q;
    logic               sign_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   dvs_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    // Request decode; op codes 5-7 behave exactly like NONE.
    logic op_valid;
    logic start;
    assign op_valid = (bus.op == OP_MULT) || (bus.op == OP_DIV) ||
                      (bus.op == OP_MADD) || (bus.op == OP_MSUB);
    assign start    = (state == S_IDLE) && op_valid && !bus.reg_flush;

    // Gated by rst so the pipeline is never held while the unit is in reset.
    assign bus.alu_stall = rst && (start || ((state == S_BUSY) && !bus.reg_flush));
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;

    // Divider works on magnitudes; signs are re-applied on the final cycle.
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    assign a_neg = bus.sign && bus.source_a[WIDTH-1];
    assign b_neg = bus.sign && bus.source_b[WIDTH-1];
    assign a_mag = a_neg ? -bus.source_a : bus.source_a;
    assign b_mag = b_neg ? -bus.source_b : bus.source_b;

    // Full-width product of the latched operands; a 2W x 2W multiply truncated
    // to 2W bits gives the correct two's-complement result for signed operands.
    logic [2*WIDTH-1:0] mul_a;
    logic [2*WIDTH-1:0] mul_b;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mul_res;
    assign mul_a = sign_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    assign mul_b = sign_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    assign prod  = mul_a * mul_b;
    assign acc   = {hi_q, lo_q};

    always_comb begin
        mul_res = prod;
        if (op_q == OP_MADD) begin
            mul_res = acc + prod;
        end else if (op_q == OP_MSUB) begin
            mul_res = acc - prod;
        end
    end

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits. rem_q < divisor always,
    // so the shifted value needs one extra bit and diff[WIDTH] is the borrow.
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             fits;
    assign rem_sh = {rem_q, quo_q[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, dvs_q};
    assign fits   = !diff[WIDTH];

    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic             div_zero;
    assign neg_q    = sign_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    assign neg_r    = sign_q && a_q[WIDTH-1];
    assign q_fix    = neg_q ? -quo_q : quo_q;
    assign r_fix    = neg_r ? -rem_q : rem_q;
    assign div_zero = (b_q == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            op_q   <= '0;
            sign_q <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q   <= bus.op;
                        sign_q <= bus.sign;
                        a_q    <= bus.source_a;
                        b_q    <= bus.source_b;
                        rem_q  <= '0;
                        quo_q  <= a_mag;
                        dvs_q  <= b_mag;
                        // cnt = number of BUSY cycles; the result is written when it reaches 1.
                        if (bus.op != OP_DIV) begin
                            cnt <= CNT_W'(MUL_CYCLES);
                        end else if (bus.source_b == '0) begin
                            cnt <= CNT_W'(1);
                        end else begin
                            cnt <= CNT_W'(WIDTH + 1);
                        end
                        state <= S_BUSY;
                    end else if (!op_valid) begin
                        if (bus.hi_write) begin
                            hi_q <= bus.source_a;
                        end
                        if (bus.lo_write) begin
                            lo_q <= bus.source_a;
                        end
                    end
                end

                S_BUSY: begin
                    cnt <= cnt - CNT_W'(1);
                    if (bus.reg_flush) begin
                        state <= S_IDLE;
                    end else if (cnt == CNT_W'(1)) begin
                        if (op_q != OP_DIV) begin
                            {hi_q, lo_q} <= mul_res;
                        end else if (div_zero) begin
                            lo_q <= '1;
                            hi_q <= a_q;
                        end else begin
                            lo_q <= q_fix;
                            hi_q <= r_fix;
                        end
                        state <= S_DONE;
                    end else if (op_q == OP_DIV) begin
                        rem_q <= fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                        quo_q <= {quo_q[WIDTH-2:0], fits};
                    end
                end

                S_DONE: begin
                    if (!bus.reg_stall || bus.reg_flush) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32, MUL_CYCLES=2) against an arithmetic reference model.
// Latency: checks stall-cycle counts per operation as seen on alu_stall.
// Backpressure: exercises reg_stall hold in DONE and reg_flush abort.
module tb_muldiv_unit;

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_MULT = 3'd1;
    localparam logic [2:0] OP_DIV  = 3'd2;
    localparam logic [2:0] OP_MADD = 3'd3;
    localparam logic [2:0] OP_MSUB = 3'd4;

    logic clk = 1'b0;
    logic rst;

    muldiv_if #(.WIDTH(32)) u ();

    muldiv_unit #(
        .WIDTH      (32),
        .MUL_CYCLES (2),
        .CNT_W      (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (u)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_hi    = '0;
    logic [31:0] m_lo    = '0;

    typedef struct {
        logic [2:0]  op;
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        int          st;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t dv[5];

    // Reference model: plain 64-bit arithmetic on the architectural HI/LO.
    function automatic void model(input logic [2:0] o, input logic s, input logic [31:0] a,
                                  input logic [31:0] b, inout logic [31:0] hi,
                                  inout logic [31:0] lo, output int st);
        longint      sa, sb, q, r;
        logic [63:0] p, acc;
        if (o == OP_DIV) begin
            st = (b == 32'd0) ? 2 : 34;
            if (b == 32'd0) begin
                lo = 32'hFFFF_FFFF;
                hi = a;
            end else if (s) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                q  = sa / sb;
                r  = sa % sb;
                lo = 32'(q);
                hi = 32'(r);
            end else begin
                lo = a / b;
                hi = a % b;
            end
        end else begin
            st = 3;
            if (s) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'({32'h0, a});
                sb = longint'({32'h0, b});
            end
            p   = 64'(sa * sb);
            acc = {hi, lo};
            if (o == OP_MADD)      acc = acc + p;
            else if (o == OP_MSUB) acc = acc - p;
            else                   acc = p;
            hi = acc[63:32];
            lo = acc[31:0];
        end
    endfunction

    // Issues one operation, holds it while alu_stall is high (scrambling the
    // operands after the start cycle) and returns the stall count plus HI/LO
    // sampled in the first cycle with alu_stall low.
    task automatic run_op(input logic [2:0] o, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input int flush_at, output int stalls,
                          output logic [31:0] ohi, output logic [31:0] olo);
        @(negedge clk);
        u.op       = o;
        u.sign     = s;
        u.source_a = a;
        u.source_b = b;
        stalls     = 0;
        for (int c = 1; c <= 200; c++) begin
            if (c == flush_at) u.reg_flush = 1'b1;
            #1;
            if (!u.alu_stall) break;
            stalls++;
            @(negedge clk);
            u.source_a = $urandom;
            u.source_b = $urandom;
        end
        ohi = u.hi;
        olo = u.lo;
        @(posedge clk);
        #1;
        u.op        = OP_NONE;
        u.reg_flush = 1'b0;
    endtask

    task automatic write_hl(input logic wh, input logic wl, input logic [31:0] d);
        @(negedge clk);
        u.hi_write = wh;
        u.lo_write = wl;
        u.source_a = d;
        @(negedge clk);
        u.hi_write = 1'b0;
        u.lo_write = 1'b0;
        #1;
        if (wh) m_hi = d;
        if (wl) m_lo = d;
    endtask

    task automatic test_reset();
        rst         = 1'b0;
        u.reg_stall = 1'b0;
        u.reg_flush = 1'b0;
        u.op        = OP_MULT;
        u.sign      = 1'b0;
        u.source_a  = 32'h1;
        u.source_b  = 32'h1;
        u.hi_write  = 1'b0;
        u.lo_write  = 1'b0;
        #12;
        n_tests++;
        if (u.alu_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stall: got %b expected 0", u.alu_stall);
        end
        n_tests++;
        if (u.hi !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_hi: got %h expected 00000000", u.hi);
        end
        n_tests++;
        if (u.lo !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_lo: got %h expected 00000000", u.lo);
        end
        u.op = OP_NONE;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_directed();
        int          st;
        logic [31:0] h, l;
        dv[0] = '{OP_MULT, 1'b1, 32'hFFFF_FFFD, 32'd5,        3,  32'hFFFF_FFFF, 32'hFFFF_FFF1};
        dv[1] = '{OP_DIV,  1'b0, 32'd100,       32'd7,        34, 32'd2,         32'd14};
        dv[2] = '{OP_DIV,  1'b1, 32'hFFFF_FFF9, 32'd2,        34, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        dv[3] = '{OP_DIV,  1'b0, 32'h0000_1234, 32'd0,        2,  32'h0000_1234, 32'hFFFF_FFFF};
        dv[4] = '{OP_DIV,  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0,        32'h8000_0000};
        for (int i = 0; i < 5; i++) begin
            run_op(dv[i].op, dv[i].s, dv[i].a, dv[i].b, 0, st, h, l);
            n_tests++;
            if (st !== dv[i].st) begin
                n_fail++;
                $display("FAIL directed%0d_stall: got %0d expected %0d", i, st, dv[i].st);
            end
            n_tests++;
            if (h !== dv[i].hi || l !== dv[i].lo) begin
                n_fail++;
                $display("FAIL directed%0d_hilo: got %h_%h expected %h_%h", i, h, l, dv[i].hi, dv[i].lo);
            end
            m_hi = dv[i].hi;
            m_lo = dv[i].lo;
        end
    endtask

    task automatic test_mtx_accumulate();
        int          st;
        logic [31:0] h, l;
        write_hl(1'b1, 1'b0, 32'd0);
        write_hl(1'b0, 1'b1, 32'd10);
        n_tests++;
        if (u.hi !== 32'd0 || u.lo !== 32'd10) begin
            n_fail++;
            $display("FAIL mthi_mtlo: got %h_%h expected 00000000_0000000a", u.hi, u.lo);
        end
        run_op(OP_MADD, 1'b0, 32'd3, 32'd4, 0, st, h, l);
        n_tests++;
        if (st !== 3 || h !== 32'd0 || l !== 32'd22) begin
            n_fail++;
            $display("FAIL madd: got st=%0d %h_%h expected st=3 00000000_00000016", st, h, l);
        end
        run_op(OP_MSUB, 1'b0, 32'd5, 32'd5, 0, st, h, l);
        n_tests++;
        if (st !== 3 || h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFFD) begin
            n_fail++;
            $display("FAIL msub: got st=%0d %h_%h expected st=3 ffffffff_fffffffd", st, h, l);
        end
        m_hi = 32'hFFFF_FFFF;
        m_lo = 32'hFFFF_FFFD;
        // MTHI alongside a flushed MULT: no start and no write.
        @(negedge clk);
        u.op        = OP_MULT;
        u.reg_flush = 1'b1;
        u.hi_write  = 1'b1;
        u.source_a  = 32'hDEAD_BEEF;
        #1;
        n_tests++;
        if (u.alu_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_blocks_start: got %b expected 0", u.alu_stall);
        end
        @(negedge clk);
        u.op        = OP_NONE;
        u.reg_flush = 1'b0;
        u.hi_write  = 1'b0;
        #1;
        n_tests++;
        if (u.hi !== m_hi || u.alu_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL write_ignored: got hi=%h stall=%b expected hi=%h stall=0", u.hi, u.alu_stall, m_hi);
        end
        // op code 5 behaves as NONE, so MTLO goes through.
        @(negedge clk);
        u.op       = 3'd5;
        u.lo_write = 1'b1;
        u.source_a = 32'hCAFE_0005;
        #1;
        n_tests++;
        if (u.alu_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL op5_stall: got %b expected 0", u.alu_stall);
        end
        @(negedge clk);
        u.op       = OP_NONE;
        u.lo_write = 1'b0;
        #1;
        m_lo = 32'hCAFE_0005;
        n_tests++;
        if (u.lo !== m_lo) begin
            n_fail++;
            $display("FAIL op5_mtlo: got %h expected %h", u.lo, m_lo);
        end
    endtask

    task automatic test_flush();
        int          st;
        logic [31:0] h, l;
        write_hl(1'b1, 1'b1, 32'h55);
        run_op(OP_DIV, 1'b0, 32'd1000, 32'd3, 10, st, h, l);
        n_tests++;
        if (st !== 9 || h !== 32'h55 || l !== 32'h55) begin
            n_fail++;
            $display("FAIL flush_div: got st=%0d %h_%h expected st=9 00000055_00000055", st, h, l);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (u.alu_stall !== 1'b0 || u.hi !== 32'h55 || u.lo !== 32'h55) begin
            n_fail++;
            $display("FAIL flush_after: got stall=%b %h_%h expected stall=0 00000055_00000055", u.alu_stall, u.hi, u.lo);
        end
    endtask

    task automatic test_held();
        int          st, e_st;
        logic [31:0] a, b, e_hi, e_lo;
        a    = $urandom;
        b    = $urandom;
        e_hi = m_hi;
        e_lo = m_lo;
        model(OP_MADD, 1'b1, a, b, e_hi, e_lo, e_st);
        @(negedge clk);
        u.op       = OP_MADD;
        u.sign     = 1'b1;
        u.source_a = a;
        u.source_b = b;
        st         = 0;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (!u.alu_stall) break;
            st++;
            @(negedge clk);
        end
        n_tests++;
        if (st !== e_st) begin
            n_fail++;
            $display("FAIL held_stall: got %0d expected %0d", st, e_st);
        end
        u.reg_stall = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            #1;
            n_tests++;
            if (u.alu_stall !== 1'b0 || u.hi !== e_hi || u.lo !== e_lo) begin
                n_fail++;
                $display("FAIL held_cycle%0d: got stall=%b %h_%h expected stall=0 %h_%h", k, u.alu_stall, u.hi, u.lo, e_hi, e_lo);
            end
        end
        u.reg_stall = 1'b0;
        @(posedge clk);
        #1;
        u.op = OP_NONE;
        @(negedge clk);
        #1;
        n_tests++;
        if (u.alu_stall !== 1'b0 || u.hi !== e_hi || u.lo !== e_lo) begin
            n_fail++;
            $display("FAIL held_release: got stall=%b %h_%h expected stall=0 %h_%h", u.alu_stall, u.hi, u.lo, e_hi, e_lo);
        end
        m_hi = e_hi;
        m_lo = e_lo;
    endtask

    task automatic test_random();
        int          st, e_st, fl;
        logic [2:0]  o;
        logic        s;
        logic [31:0] a, b, h, l, e_hi, e_lo;
        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(1, 4));
            s = 1'($urandom);
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 5) == 0) b = 32'd0;
            if ($urandom_range(0, 9) == 0) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            if ($urandom_range(0, 7) == 0) b = b >> $urandom_range(1, 31);
            e_hi = m_hi;
            e_lo = m_lo;
            model(o, s, a, b, e_hi, e_lo, e_st);
            fl = ($urandom_range(0, 7) == 0) ? $urandom_range(1, e_st) : 0;
            if (fl != 0) begin
                e_st = fl - 1;
                e_hi = m_hi;
                e_lo = m_lo;
            end
            run_op(o, s, a, b, fl, st, h, l);
            n_tests++;
            if (st !== e_st || h !== e_hi || l !== e_lo) begin
                n_fail++;
                $display("FAIL random%0d op=%0d s=%0d a=%h b=%h fl=%0d: got st=%0d %h_%h expected st=%0d %h_%h",
                         i, o, s, a, b, fl, st, h, l, e_st, e_hi, e_lo);
            end
            m_hi = e_hi;
            m_lo = e_lo;
        end
    endtask

    task automatic test_async_reset();
        int          st, e_st;
        logic [31:0] h, l, e_hi, e_lo;
        write_hl(1'b1, 1'b1, 32'hA5A5_1234);
        @(negedge clk);
        u.op       = OP_DIV;
        u.sign     = 1'b0;
        u.source_a = 32'hFFFF_0000;
        u.source_b = 32'd9;
        repeat (5) @(negedge clk);
        #3;
        rst = 1'b0;
        #1;
        n_tests++;
        if (u.hi !== 32'h0 || u.lo !== 32'h0 || u.alu_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got stall=%b %h_%h expected stall=0 00000000_00000000", u.alu_stall, u.hi, u.lo);
        end
        u.op = OP_NONE;
        #7;
        rst  = 1'b1;
        m_hi = 32'h0;
        m_lo = 32'h0;
        e_hi = m_hi;
        e_lo = m_lo;
        model(OP_MADD, 1'b0, 32'd7, 32'd6, e_hi, e_lo, e_st);
        run_op(OP_MADD, 1'b0, 32'd7, 32'd6, 0, st, h, l);
        n_tests++;
        if (st !== e_st || h !== e_hi || l !== e_lo) begin
            n_fail++;
            $display("FAIL post_reset_madd: got st=%0d %h_%h expected st=%0d %h_%h", st, h, l, e_st, e_hi, e_lo);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mtx_accumulate();
        test_flush();
        test_held();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
